// File: rtl/conv_pkg.sv
// Shared types and constants for the conv_layer_sched sequencer.
// The pooling states exist only when CONV_POOL_EN is defined.
package conv_pkg;

  localparam int IMG_W   = 64;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 20;
  localparam int COORD_W = $clog2(IMG_W);
  localparam int POOL_CW = COORD_W - 1;

  localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(IMG_W - 1);
  localparam logic [POOL_CW-1:0] POOL_MAX  = POOL_CW'(IMG_W / 2 - 1);
  localparam logic [3:0]         TAP_LAST  = 4'd8;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    CONV_TAP,
    CONV_WAIT,
    CONV_WR,
`ifdef CONV_POOL_EN
    POOL_RD,
    POOL_WR,
`endif
    DONE
  } state_t;

  // Tap offsets in two's complement, each -1..+1.
  typedef struct packed {
    logic [1:0] dy;
    logic [1:0] dx;
  } tap_off_t;

  // Row-major 3x3 neighbourhood: (dy,dx) = (idx/3-1, idx%3-1).
  function automatic tap_off_t tap_offset(input logic [3:0] idx);
    case (idx)
      4'd0:    return '{dy: 2'b11, dx: 2'b11};
      4'd1:    return '{dy: 2'b11, dx: 2'b00};
      4'd2:    return '{dy: 2'b11, dx: 2'b01};
      4'd3:    return '{dy: 2'b00, dx: 2'b11};
      4'd4:    return '{dy: 2'b00, dx: 2'b00};
      4'd5:    return '{dy: 2'b00, dx: 2'b01};
      4'd6:    return '{dy: 2'b01, dx: 2'b11};
      4'd7:    return '{dy: 2'b01, dx: 2'b00};
      4'd8:    return '{dy: 2'b01, dx: 2'b01};
      default: return '{dy: 2'b00, dx: 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/conv_tap_addr_gen.sv
// Combinational tap address generator: neighbour address for (x,y,tap_idx),
// falling back to the centre address with tap_zero set when off-image.
module conv_tap_addr_gen
  import conv_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [3:0]         tap_idx,
  output logic [ADDR_W-1:0]  iaddr,
  output logic               tap_zero
);

  tap_off_t           off;
  logic [COORD_W+1:0] nx;
  logic [COORD_W+1:0] ny;
  logic               in_bounds;

  // Two guard bits catch both -1 (wraps to all ones) and IMG_W (carry out).
  always_comb begin
    off       = tap_offset(tap_idx);
    ny        = {2'b00, y} + {{COORD_W{off.dy[1]}}, off.dy};
    nx        = {2'b00, x} + {{COORD_W{off.dx[1]}}, off.dx};
    in_bounds = (ny[COORD_W+1:COORD_W] == 2'b00) && (nx[COORD_W+1:COORD_W] == 2'b00);
    tap_zero  = !in_bounds;
    iaddr     = in_bounds ? {ny[COORD_W-1:0], nx[COORD_W-1:0]} : {y, x};
  end

endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: walks the image issuing 3x3 taps to the external MAC,
// writes results to layer 0, then (with CONV_POOL_EN defined) 2x2 max-pools
// layer 0 into layer 1 over the shared cmem port.
module conv_layer_sched
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  output logic              tap_vld,
  output logic [3:0]        tap_idx,
  output logic              tap_zero,
  output logic              tap_last,
  input  logic              res_vld,
  input  logic [DATA_W-1:0] res_data,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic [2:0]        csel
);

  state_t             state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COORD_W-1:0] x_inc;
  logic [COORD_W-1:0] y_inc;
  logic [3:0]         tap;
  logic [ADDR_W-1:0]  tap_addr;
  logic               tap_oob;
  logic               last_pixel;

  conv_tap_addr_gen u_tap_addr (
    .x        (x),
    .y        (y),
    .tap_idx  (tap),
    .iaddr    (tap_addr),
    .tap_zero (tap_oob)
  );

  // Tap outputs are qualified by the tap state so they read 0 elsewhere.
  assign tap_vld    = (state == CONV_TAP);
  assign tap_idx    = tap;
  assign tap_last   = tap_vld && (tap == TAP_LAST);
  assign tap_zero   = tap_vld && tap_oob;
  assign iaddr      = tap_vld ? tap_addr : '0;
  assign x_inc      = x + COORD_W'(1);
  assign y_inc      = y + COORD_W'(1);
  assign last_pixel = (x == COORD_MAX) && (y == COORD_MAX);

`ifdef CONV_POOL_EN
  logic [POOL_CW-1:0]       px;
  logic [POOL_CW-1:0]       py;
  logic [POOL_CW-1:0]       px_inc;
  logic [POOL_CW-1:0]       py_inc;
  logic [2:0]               pcnt;
  logic [1:0]               rd_k;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] max_next;
  logic                     crd_q;
  logic [ADDR_W-1:0]        caddr_rd_q;
  logic                     last_group;

  assign px_inc     = px + POOL_CW'(1);
  assign py_inc     = py + POOL_CW'(1);
  assign rd_k       = pcnt[1:0] + 2'd1;
  assign max_next   = ($signed(cdata_rd) > max_q) ? $signed(cdata_rd) : max_q;
  assign last_group = (px == POOL_MAX) && (py == POOL_MAX);
  assign crd        = crd_q;
  assign caddr_rd   = caddr_rd_q;
`else
  logic unused_cdata_rd;
  assign unused_cdata_rd = ^cdata_rd;
  assign crd             = 1'b0;
  assign caddr_rd        = '0;
`endif

  // Sequencer FSM with registered handshake and memory-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      x        <= '0;
      y        <= '0;
      tap      <= '0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= CSEL_NONE;
`ifdef CONV_POOL_EN
      px         <= '0;
      py         <= '0;
      pcnt       <= '0;
      max_q      <= '0;
      crd_q      <= 1'b0;
      caddr_rd_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ready) begin
            busy  <= 1'b1;
            x     <= '0;
            y     <= '0;
            tap   <= '0;
            state <= CONV_TAP;
          end
        end
        CONV_TAP: begin
          if (tap == TAP_LAST) begin
            tap   <= '0;
            state <= CONV_WAIT;
          end else begin
            tap <= tap + 4'd1;
          end
        end
        CONV_WAIT: begin
          if (res_vld) begin
            cwr      <= 1'b1;
            csel     <= CSEL_L0;
            caddr_wr <= {y, x};
            cdata_wr <= res_data;
            state    <= CONV_WR;
          end
        end
        CONV_WR: begin
          cwr  <= 1'b0;
          csel <= CSEL_NONE;
          if (x == COORD_MAX) begin
            x <= '0;
            y <= y_inc;
          end else begin
            x <= x_inc;
          end
          if (last_pixel) begin
`ifdef CONV_POOL_EN
            crd_q      <= 1'b1;
            csel       <= CSEL_L0;
            caddr_rd_q <= '0;
            px         <= '0;
            py         <= '0;
            pcnt       <= '0;
            state      <= POOL_RD;
`else
            busy  <= 1'b0;
            state <= DONE;
`endif
          end else begin
            state <= CONV_TAP;
          end
        end
`ifdef CONV_POOL_EN
        // pcnt 0..3 issue reads; read data trails by one cycle, so the
        // fourth datum is folded into the max on pcnt 4.
        POOL_RD: begin
          pcnt <= pcnt + 3'd1;
          if (pcnt == 3'd1) begin
            max_q <= cdata_rd;
          end else if (pcnt >= 3'd2) begin
            max_q <= max_next;
          end
          if (pcnt < 3'd3) begin
            caddr_rd_q <= {py, rd_k[1], px, rd_k[0]};
          end else if (pcnt == 3'd3) begin
            crd_q <= 1'b0;
            csel  <= CSEL_NONE;
          end else begin
            cwr      <= 1'b1;
            csel     <= CSEL_L1;
            caddr_wr <= ADDR_W'({py, px});
            cdata_wr <= max_next;
            pcnt     <= '0;
            state    <= POOL_WR;
          end
        end
        POOL_WR: begin
          cwr <= 1'b0;
          if (last_group) begin
            csel  <= CSEL_NONE;
            busy  <= 1'b0;
            px    <= '0;
            py    <= '0;
            state <= DONE;
          end else begin
            crd_q <= 1'b1;
            csel  <= CSEL_L0;
            state <= POOL_RD;
            if (px == POOL_MAX) begin
              px         <= '0;
              py         <= py_inc;
              caddr_rd_q <= {py_inc, 1'b0, {POOL_CW{1'b0}}, 1'b0};
            end else begin
              px         <= px_inc;
              caddr_rd_q <= {py, 1'b0, px_inc, 1'b0};
            end
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Self-checking bench for conv_layer_sched: tap table for pixel (0,0), a
// cycle monitor checking every tap/write/read against an arithmetic image
// model, a MAC model with randomized latency and data, and a layer-0 memory.
`timescale 1ns/1ps
module tb_conv_layer_sched;

  localparam int W = 64;
  localparam int N = W * W;
  localparam int G = (W / 2) * (W / 2);

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic        tap_vld;
  logic [3:0]  tap_idx;
  logic        tap_zero;
  logic        tap_last;
  logic        res_vld;
  logic [19:0] res_data;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;

  conv_layer_sched dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .busy     (busy),
    .iaddr    (iaddr),
    .tap_vld  (tap_vld),
    .tap_idx  (tap_idx),
    .tap_zero (tap_zero),
    .tap_last (tap_last),
    .res_vld  (res_vld),
    .res_data (res_data),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [19:0] v);
    return int'($signed(v));
  endfunction

  // Scoreboard state shared by the monitor and the models.
  logic [19:0] mac_mem [N];
  logic [19:0] l0_mem  [N];
  bit  mon_en = 0;
  bit  full_job = 0;
  int  cyc = 0;
  int  conv_n, pool_n, rd_n, tap_n, taps_seen, crd_total;
  int  tlast_cyc, first_rd_cyc, last_pwr_cyc, final_wr_cyc;
  int  cur_lat = 3;
  int  first_pool_data = -1, first_pool_addr = -1;
  bit  prev_cwr = 0, prev_busy = 0;
  int  m_dy, m_dx, m_yy, m_xx, m_base, m_max, m_v;
  bit  m_oob;
  logic [2:0] m_csel;

  task automatic clear_sb();
    conv_n = 0; pool_n = 0; rd_n = 0; tap_n = 0; taps_seen = 0; crd_total = 0;
    tlast_cyc = -1000; first_rd_cyc = -1000; last_pwr_cyc = -1000; final_wr_cyc = -1000;
    first_pool_data = -1; first_pool_addr = -1;
  endtask

  // Monitor: every cycle, check strobes, taps and writes against the image model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (cwr || crd || csel != 3'b000) begin
          chk("strobe_excl", cwr & crd, 0);
          m_csel = crd ? 3'b001 : (cwr ? (conv_n < N ? 3'b001 : 3'b011) : 3'b000);
          chk("csel", csel, m_csel);
        end
        if (cwr) chk("cwr_pulse", prev_cwr, 0);
        if (tap_vld) begin
          m_dy = tap_n / 3 - 1;
          m_dx = tap_n % 3 - 1;
          m_yy = conv_n / W + m_dy;
          m_xx = conv_n % W + m_dx;
          m_oob = (m_yy < 0) || (m_yy >= W) || (m_xx < 0) || (m_xx >= W);
          chk("tap_idx", tap_idx, tap_n);
          chk("tap_zero", tap_zero, m_oob);
          chk("iaddr", iaddr, m_oob ? conv_n : m_yy * W + m_xx);
          chk("tap_last", tap_last, tap_n == 8);
          if (tap_n == 8) tlast_cyc = cyc;
          tap_n = (tap_n + 1) % 9;
          taps_seen++;
        end
        if (crd) begin
          chk("crd_after_conv", conv_n, N);
          m_base = (pool_n / 32) * 2 * W + (pool_n % 32) * 2;
          chk("pool_raddr", caddr_rd, m_base + (rd_n / 2) * W + rd_n % 2);
          if (rd_n == 0) begin
            first_rd_cyc = cyc;
            if (pool_n > 0) chk("pool_gap", cyc - last_pwr_cyc, 1);
          end
          rd_n++;
          crd_total++;
        end
        if (cwr && conv_n < N) begin
          chk("conv_taps", taps_seen, 9);
          chk("conv_lat", cyc - tlast_cyc, cur_lat + 1);
          chk("conv_addr", caddr_wr, conv_n);
          chk("conv_data", cdata_wr, mac_mem[conv_n]);
          l0_mem[conv_n] = cdata_wr;
          taps_seen = 0;
          conv_n++;
`ifndef CONV_POOL_EN
          if (conv_n == N) final_wr_cyc = cyc;
`endif
        end else if (cwr) begin
          m_base = (pool_n / 32) * 2 * W + (pool_n % 32) * 2;
          m_max = sx(mac_mem[m_base]);
          for (int k = 1; k < 4; k++) begin
            m_v = sx(mac_mem[m_base + (k / 2) * W + k % 2]);
            if (m_v > m_max) m_max = m_v;
          end
          chk("pool_reads", rd_n, 4);
          chk("pool_lat", cyc - first_rd_cyc, 5);
          chk("pool_addr", caddr_wr, pool_n);
          chk("pool_data", cdata_wr, m_max[19:0]);
          if (pool_n == 0) begin
            first_pool_data = int'(cdata_wr);
            first_pool_addr = int'(caddr_wr);
          end
          last_pwr_cyc = cyc;
          rd_n = 0;
          pool_n++;
          if (pool_n == G) final_wr_cyc = cyc;
        end
        if (full_job && prev_busy && !busy) chk("busy_fall", cyc - final_wr_cyc, 1);
      end
      prev_cwr  = cwr;
      prev_busy = busy;
    end
  end

  // MAC model: result L cycles after tap_last; random junk and spurious
  // res_vld pulses during taps must be ignored by the DUT.
  int res_cnt = 0;
  int res_pix = 0;
  initial begin
    res_vld  = 1'b0;
    res_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        res_cnt = 0;
        res_vld = 1'b0;
      end else begin
        res_vld  = 1'b0;
        res_data = 20'($urandom);
        if (res_cnt > 0) begin
          res_cnt--;
          if (res_cnt == 0) begin
            res_vld  = 1'b1;
            res_data = mac_mem[res_pix];
          end
        end else if (tap_vld && $urandom_range(0, 3) == 0) begin
          res_vld = 1'b1;
        end
        if (tap_last) begin
          cur_lat = full_job ? int'($urandom_range(1, 4)) : 3;
          res_cnt = cur_lat;
          res_pix = conv_n;
        end
      end
    end
  end

  // Layer-0 read port: data for a read appears in the following cycle.
  bit          rd_pend;
  logic [11:0] rd_a;
  initial begin
    cdata_rd = '0;
    forever begin
      @(negedge clk);
      rd_pend = crd;
      rd_a    = caddr_rd;
      @(posedge clk);
      #1;
      cdata_rd = rd_pend ? l0_mem[rd_a] : 20'($urandom);
    end
  end

  typedef struct {
    int idx;
    bit zero;
    int addr;
    bit last;
  } tap_vec_t;

  tap_vec_t tv [9];
  int n;
  int busy_hi;

  initial begin
    tv[0] = '{0, 1, 0, 0};
    tv[1] = '{1, 1, 0, 0};
    tv[2] = '{2, 1, 0, 0};
    tv[3] = '{3, 1, 0, 0};
    tv[4] = '{4, 0, 0, 0};
    tv[5] = '{5, 0, 1, 0};
    tv[6] = '{6, 1, 0, 0};
    tv[7] = '{7, 0, 64, 0};
    tv[8] = '{8, 0, 65, 1};
    for (int i = 0; i < N; i++) l0_mem[i] = '0;
    clear_sb();

    // Reset, then idle with ready low.
    reset = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tap_vld", tap_vld, 0);
    chk("rst_tap_idx", tap_idx, 0);
    chk("rst_tap_zero", tap_zero, 0);
    chk("rst_tap_last", tap_last, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_cwr", cwr, 0);
    chk("rst_caddr_wr", caddr_wr, 0);
    chk("rst_cdata_wr", cdata_wr, 0);
    chk("rst_crd", crd, 0);
    chk("rst_caddr_rd", caddr_rd, 0);
    chk("rst_csel", csel, 0);
    busy_hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    chk("idle_busy_cycles", busy_hi, 0);

    // Short job: constant MAC data, L=3; taps of pixel (0,0) from the table.
    for (int i = 0; i < N; i++) mac_mem[i] = 20'h01310;
    clear_sb();
    full_job = 0;
    mon_en = 1;
    ready = 1'b1;
    @(negedge clk);
    chk("start_busy", busy, 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      ready = 1'($urandom_range(0, 1));
      chk("tbl_tap_vld", tap_vld, 1);
      chk("tbl_tap_idx", tap_idx, tv[i].idx);
      chk("tbl_tap_zero", tap_zero, tv[i].zero);
      chk("tbl_tap_last", tap_last, tv[i].last);
      if (!tv[i].zero) chk("tbl_iaddr", iaddr, tv[i].addr);
    end

    // Run to pixel 100's tap_last, then reset during its CONV_WAIT.
    n = 0;
    while (!(tap_last && conv_n == 100) && n < 5000) begin
      @(negedge clk);
      ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("reach_px100", n < 5000, 1);
    @(negedge clk);
    mon_en = 0;
    ready = 1'b0;
    chk("wait_busy", busy, 1);
    chk("wait_tap_vld", tap_vld, 0);
    chk("wait_cwr", cwr, 0);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cwr", cwr, 0);
    chk("midrst_csel", csel, 0);
    chk("midrst_tap_vld", tap_vld, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // Full job: random data and latency, pool corner values at 0,1,64,65.
    for (int i = 0; i < N; i++) mac_mem[i] = 20'($urandom);
    mac_mem[0]  = 20'hFFFFB;
    mac_mem[1]  = 20'h00007;
    mac_mem[64] = 20'h00003;
    mac_mem[65] = 20'hFFFFE;
    clear_sb();
    full_job = 1;
    mon_en = 1;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("job_busy", busy, 1);
    n = 0;
    while (busy && n < 90000) begin
      @(negedge clk);
      n++;
      if (busy) ready = (n % 7 == 0);
      else ready = 1'b0;
    end
    ready = 1'b0;
    chk("job_done", n < 90000, 1);
    chk("conv_total", conv_n, N);
`ifdef CONV_POOL_EN
    chk("pool_total", pool_n, G);
    chk("pool0_addr", first_pool_addr, 0);
    chk("pool0_data", first_pool_data, 7);
`else
    chk("crd_total", crd_total, 0);
`endif
    repeat (4) @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_tap_vld", tap_vld, 0);
    chk("end_cwr", cwr, 0);
    chk("end_csel", csel, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
